game_timer_display: RTL
=======================

Name: game_timer_display

Overview:
- Consumes the 1 Hz and scan-rate square waves produced by the system clock divider.
- Runs a BCD countdown game timer and multiplexes timer plus score onto a 4-digit common-anode seven-segment display.
- Everything runs on the system clock. The divided waves are treated as data and rising-edge detected, never used as clocks.
- Sits between the clock divider/game controller and the board display pins.

Parameters:
- START_SECS, 8'h30, reload value of the countdown as 2-digit BCD; legal range 8'h01..8'h99.
- SCORE_EN, 1, 1 = digits 3..2 show score_bcd; 0 = digits 3..2 blanked.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_1hz_in  in  1  1 Hz square wave from the clock divider
- clk_scan_in  in  1  scan-rate square wave from the clock divider
- start  in  1  single-cycle pulse; start/restart a round
- pause  in  1  single-cycle pulse; toggle pause while a round is active
- score_bcd  in  8  current score, 2-digit BCD
- time_bcd  out  8  remaining seconds, BCD
- running  out  1  high in RUN state
- time_up  out  1  single-cycle pulse when the countdown reaches 00
- an  out  4  digit enables, active-low one-hot
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset is asynchronous, active-low, all flops:
  - state=IDLE, time_bcd=START_SECS
  - edge-detect history regs=0, digit index=0
  - running=0, time_up=0, an=4'b1111, seg=7'b1111111
- Edge detect:
  - tick_1hz = clk_1hz_in & ~prev_1hz
  - tick_scan = clk_scan_in & ~prev_scan
  - prev_* register the inputs every cycle.
  - A tick is a one-cycle internal strobe, one clk after the input rises. Inputs are synchronous to clk, so no synchroniser is needed.
- FSM states: IDLE, RUN, PAUSED, DONE.
  - IDLE: time_bcd holds START_SECS. start -> RUN. pause ignored.
  - RUN:
    - On tick_1hz, decrement time_bcd in BCD. Ones 0 -> ones 9, tens-1.
    - If time_bcd==8'h01 at the tick: time_bcd becomes 8'h00, time_up=1 for exactly that next cycle, state -> DONE.
    - pause -> PAUSED.
    - start -> reload START_SECS and stay in RUN.
  - PAUSED: tick_1hz ignored, time_bcd frozen. pause -> RUN. start -> reload START_SECS, RUN.
  - DONE: time_bcd holds 8'h00. start -> reload START_SECS, RUN. pause ignored.
- Priority for simultaneous events in the same cycle: start > pause > tick_1hz.
  - Exception: tick_1hz and pause together in RUN apply the decrement AND enter PAUSED.
  - This also holds when the decrement reaches 00: time_up fires and the state goes to DONE, not PAUSED.
- running = (state==RUN), registered; updates the same edge as the state register.
- Scan:
  - 2-bit digit index increments on tick_scan, wrapping 3->0.
  - Digit map: 0 = time ones, 1 = time tens, 2 = score ones, 3 = score tens.
  - an and seg are registered from the current index and digit values every cycle, one-cycle latency after an index or value change.
  - an = ~(4'b0001 << index).
- Seven-segment decode:
  - BCD 0..9 uses standard active-low patterns, e.g. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - Nibbles 10..15 decode blank (7'b1111111).
  - SCORE_EN=0 forces blank on digits 2..3; an still scans.
- Reset mid-round returns immediately to IDLE with START_SECS; no time_up is generated.

Decomposition:
- Shared package game_pkg:
  - FSM state enum (2-bit)
  - SEG_BLANK constant and the ten segment pattern constants
  - digit index width constant
- One sub-module, seg7_decoder: purely combinational, 4-bit BCD in, 7-bit active-low segments out, blank for >9.
- Everything else stays in game_timer_display.

Test Plan:
- Reset then idle (START_SECS=8'h30): release rst_n, no start, toggle clk_1hz_in 5 periods -> time_bcd stays 8'h30, running=0, an=4'b1111 until the first post-reset clk, then 4'b1110.
- Countdown and BCD borrow: start pulse, 11 rising edges of clk_1hz_in -> time_bcd 8'h29 after the 1st edge, 8'h20 after the 10th, 8'h19 after the 11th. Each update lands 2 clks after the input rises.
- Expiry: START_SECS=8'h02, start, 2 rising 1 Hz edges -> time_bcd=8'h00, time_up high exactly 1 cycle, state DONE. A further 1 Hz edge leaves time_bcd 8'h00 and time_up 0.
- Pause and simultaneity:
  - At 8'h25, pause -> 3 edges ignored, time_bcd 8'h25. Pause again -> next edge gives 8'h24.
  - pause coincident with tick_1hz at 8'h24 -> 8'h23 and PAUSED.
  - start+pause together in PAUSED -> 8'h30, RUN.
- Scan mux: score_bcd=8'h47, time_bcd=8'h30, 5 scan rising edges -> an sequence 1110, 1101, 1011, 0111, 1110. seg = 0 (1000000), 3 (0110000), 7 (1111000), 4 (0011001), 0. score_bcd=8'h4C -> digit 2 blank 1111111.
- Async reset mid-round: assert rst_n low between clk edges at time_bcd=8'h17 -> all outputs take reset values immediately, no time_up. After release, start -> 8'h30 and RUN.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game timer and its seven-segment display.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DIG_W = 2;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Any non-BCD nibble decodes blank; this one is used to force a blank digit.
    localparam logic [3:0] NIBBLE_BLANK = 4'hF;

    // Two-digit BCD decrement; callers never pass 8'h00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD nibbles blank.
module seg7_decoder
    import game_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/game_timer_display.sv
// BCD countdown game timer with a 4-digit multiplexed seven-segment display.
// The divider square waves are sampled as data and edge-detected on clk.
module game_timer_display
    import game_pkg::*;
#(
    parameter logic [7:0] START_SECS = 8'h30,
    parameter bit         SCORE_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_1hz_in,
    input  logic       clk_scan_in,
    input  logic       start,
    input  logic       pause,
    input  logic [7:0] score_bcd,
    output logic [7:0] time_bcd,
    output logic       running,
    output logic       time_up,
    output logic [3:0] an,
    output logic [6:0] seg
);

    logic             prev_1hz;
    logic             prev_scan;
    logic             tick_1hz;
    logic             tick_scan;
    state_t           state;
    state_t           state_next;
    logic [7:0]       time_next;
    logic             time_up_next;
    logic [DIG_W-1:0] dig_idx;
    logic [3:0]       dig_val;
    logic [6:0]       dig_seg;

    // Ticks are registered strobes, so a countdown step lands two clks after the wave rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_1hz  <= 1'b0;
            prev_scan <= 1'b0;
            tick_1hz  <= 1'b0;
            tick_scan <= 1'b0;
        end else begin
            prev_1hz  <= clk_1hz_in;
            prev_scan <= clk_scan_in;
            tick_1hz  <= clk_1hz_in & ~prev_1hz;
            tick_scan <= clk_scan_in & ~prev_scan;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            time_bcd <= START_SECS;
            running  <= 1'b0;
            time_up  <= 1'b0;
        end else begin
            state    <= state_next;
            time_bcd <= time_next;
            running  <= (state_next == ST_RUN);
            time_up  <= time_up_next;
        end
    end

    // start beats pause beats tick, except that a tick and pause in RUN both take effect.
    always_comb begin
        state_next   = state;
        time_next    = time_bcd;
        time_up_next = 1'b0;
        case (state)
            ST_IDLE: begin
                time_next = START_SECS;
                if (start)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (start) begin
                    time_next = START_SECS;
                end else begin
                    if (pause)
                        state_next = ST_PAUSED;
                    if (tick_1hz) begin
                        if (time_bcd == 8'h01) begin
                            time_next    = 8'h00;
                            time_up_next = 1'b1;
                            state_next   = ST_DONE;
                        end else begin
                            time_next = bcd_dec(time_bcd);
                        end
                    end
                end
            end
            ST_PAUSED: begin
                if (start) begin
                    time_next  = START_SECS;
                    state_next = ST_RUN;
                end else if (pause) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                time_next = 8'h00;
                if (start) begin
                    time_next  = START_SECS;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
                time_next  = START_SECS;
            end
        endcase
    end

    always_comb begin
        dig_val = NIBBLE_BLANK;
        case (dig_idx)
            2'd0:    dig_val = time_bcd[3:0];
            2'd1:    dig_val = time_bcd[7:4];
            2'd2:    dig_val = SCORE_EN ? score_bcd[3:0] : NIBBLE_BLANK;
            2'd3:    dig_val = SCORE_EN ? score_bcd[7:4] : NIBBLE_BLANK;
            default: dig_val = NIBBLE_BLANK;
        endcase
    end

    seg7_decoder u_dec (
        .bcd (dig_val),
        .seg (dig_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_idx <= '0;
            an      <= 4'b1111;
            seg     <= SEG_BLANK;
        end else begin
            if (tick_scan)
                dig_idx <= dig_idx + DIG_W'(1);
            an  <= ~(4'b0001 << dig_idx);
            seg <= dig_seg;
        end
    end

endmodule
